// File: rtl/mc_pkg.sv
// Shared definitions for the SRAM memory controller: FSM encoding,
// bus widths and the inactive level of the active-low SRAM strobes.
package mc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mc_state_e;

    localparam int SRAM_DATA_W = 16;
    localparam int WORD_W      = 32;

    // Wide enough for the largest legal stretch of 7 extra cycles.
    localparam int WAIT_W = 3;

    // All SRAM strobes are active-low, so "off" is a logic one.
    localparam logic STROBE_INACTIVE = 1'b1;

endpackage

// File: rtl/mc_wait_counter.sv
// Loadable down-counter that stretches each half-word SRAM access.
// The controller loads it on every state entry; the zero flag marks the
// last cycle of the current half-word access.
module mc_wait_counter
    import mc_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic [WAIT_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic              zero_o
);

    logic [WAIT_W-1:0] count_q;

    // Reload on request, otherwise count down and hold at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/sram_memory_controller.sv
// Memory-stage to external asynchronous SRAM bridge. Each 32-bit word is
// transferred as two 16-bit accesses (low half at the even SRAM address).
// Optional macro MC_ACCESS_COUNT_EN adds saturating read/write access counters.
module sram_memory_controller
    import mc_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 18
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   mem_mc_en,
    input  logic                   mem_mc_rw,
    input  logic [ADDR_W-1:0]      mem_mc_addr,
    inout  logic [WORD_W-1:0]      mem_mc_data,
    output logic                   mc_busy,
    output logic                   mc_done,
    output logic [ADDR_W-1:0]      sram_addr,
    inout  logic [SRAM_DATA_W-1:0] sram_dq,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
`ifdef MC_ACCESS_COUNT_EN
    ,
    output logic [15:0]            mc_rd_count,
    output logic [15:0]            mc_wr_count
`endif
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

    mc_state_e               state_q, state_d;
    logic [ADDR_W-2:0]       addr_q, addr_d;
    logic                    rw_q, rw_d;
    logic [WORD_W-1:0]       wdata_q, wdata_d;
    logic [WORD_W-1:0]       rdata_q, rdata_d;
    logic                    dq_oe;
    logic [SRAM_DATA_W-1:0]  dq_out;
    logic                    wait_load, wait_dec, wait_zero;

    // The top word-address bit has no SRAM storage behind it.
    logic unused_addr_msb;
    assign unused_addr_msb = mem_mc_addr[ADDR_W-1];

    mc_wait_counter u_wait (
        .clock      (clock),
        .reset      (reset),
        .load_i     (wait_load),
        .load_val_i (WAIT_LOAD),
        .dec_i      (wait_dec),
        .zero_o     (wait_zero)
    );

    // State, latched request and assembled read word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state, request capture and SRAM strobes for the current half-word.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        sram_addr = '0;
        sram_ce_n = STROBE_INACTIVE;
        sram_oe_n = STROBE_INACTIVE;
        sram_we_n = STROBE_INACTIVE;
        sram_ub_n = STROBE_INACTIVE;
        sram_lb_n = STROBE_INACTIVE;
        dq_oe     = 1'b0;
        dq_out    = '0;
        wait_load = 1'b1;
        wait_dec  = 1'b0;
        mc_busy   = (state_q != IDLE);
        mc_done   = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (mem_mc_en) begin
                    addr_d  = mem_mc_addr[ADDR_W-2:0];
                    rw_d    = mem_mc_rw;
                    if (mem_mc_rw) begin
                        wdata_d = mem_mc_data;
                    end
                    state_d = LO;
                end
            end
            LO, HI: begin
                sram_addr = {addr_q, (state_q == HI)};
                sram_ce_n = 1'b0;
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
                if (rw_q) begin
                    sram_we_n = 1'b0;
                    dq_oe     = 1'b1;
                    dq_out    = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
                end else begin
                    sram_oe_n = 1'b0;
                end
                wait_load = 1'b0;
                wait_dec  = 1'b1;
                if (wait_zero) begin
                    wait_load = 1'b1;
                    if (state_q == HI) begin
                        if (!rw_q) begin
                            rdata_d[31:16] = sram_dq;
                        end
                        state_d = DONE;
                    end else begin
                        if (!rw_q) begin
                            rdata_d[15:0] = sram_dq;
                        end
                        state_d = HI;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sram_dq     = dq_oe ? dq_out : 'z;
    assign mem_mc_data = (mem_mc_en && !mem_mc_rw) ? rdata_q : 'z;

`ifdef MC_ACCESS_COUNT_EN
    logic [15:0] rd_count_q, wr_count_q;
    logic        enter_done;

    assign enter_done = (state_q == HI) && (state_d == DONE);

    // Count completed accesses by type, saturating at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (enter_done) begin
            if (rw_q) begin
                if (wr_count_q != 16'hFFFF) begin
                    wr_count_q <= wr_count_q + 16'd1;
                end
            end else begin
                if (rd_count_q != 16'hFFFF) begin
                    rd_count_q <= rd_count_q + 16'd1;
                end
            end
        end
    end

    assign mc_rd_count = rd_count_q;
    assign mc_wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_sram_memory_controller.sv
// Scoreboard bench for sram_memory_controller. Two controllers run side by
// side (WAIT_STATES 0 and 3), each with its own SRAM model and word-level
// reference memory; expected completions are queued at issue time and a
// monitor pops them whenever mc_done is seen.
`timescale 1ns/1ps
module tb_sram_memory_controller;

    typedef struct {
        bit          isRead;
        logic [31:0] data;
        int          doneEdge;
    } exp_t;

    logic clock = 1'b0;
    int   edgeCount = 0;
    int   compared = 0;
    int   mismatched = 0;
    bit   laneDone [2];

    // Free-running clock
    always #5 clock = ~clock;

    // Number of rising edges so far; timing expectations are stated in it
    always @(posedge clock) edgeCount <= edgeCount + 1;

    // Equality comparison with a pass/fail tally
    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    // Comparison that requires a value to be absent from the bus
    task automatic checkDiffer(input string name, input logic [31:0] actual, input logic [31:0] forbidden);
        compared++;
        if (actual === forbidden) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, required anything but 0x%08h", name, actual, forbidden);
        end
    endtask

    // An expected event never happened (or an unexpected one did)
    task automatic failNote(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got no matching event, required one", name);
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int WS  = (g == 0) ? 0 : 3;
        localparam int LAT = 2 * (WS + 1);

        logic        reset, en, rw, tbDrive;
        logic [17:0] addr;
        logic [31:0] tbData;
        wire  [31:0] mcData;
        wire  [15:0] sramDq;
        logic        busy, done;
        logic [17:0] sramAddr;
        logic        ceN, oeN, weN, ubN, lbN;
`ifdef MC_ACCESS_COUNT_EN
        logic [15:0] rdCount, wrCount;
`endif
        logic [15:0] sramMem [0:262143];
        logic [31:0] refMem [int];
        exp_t        sbQ [$];
        logic [31:0] lastRead;
        int          refRd, refWr;

        assign mcData = tbDrive ? tbData : 'z;

        // Asynchronous SRAM: reads are combinational, writes land mid-cycle
        assign sramDq = (!ceN && !oeN && weN) ? sramMem[sramAddr] : 'z;

        initial begin
            for (int i = 0; i < 262144; i++) sramMem[i] = 16'h0;
        end

        always @(negedge clock) begin
            if (!ceN && !weN) sramMem[sramAddr] = sramDq;
        end

        sram_memory_controller #(.WAIT_STATES(WS), .ADDR_W(18)) dut (
            .clock       (clock),
            .reset       (reset),
            .mem_mc_en   (en),
            .mem_mc_rw   (rw),
            .mem_mc_addr (addr),
            .mem_mc_data (mcData),
            .mc_busy     (busy),
            .mc_done     (done),
            .sram_addr   (sramAddr),
            .sram_dq     (sramDq),
            .sram_ce_n   (ceN),
            .sram_oe_n   (oeN),
            .sram_we_n   (weN),
            .sram_ub_n   (ubN),
            .sram_lb_n   (lbN)
`ifdef MC_ACCESS_COUNT_EN
            ,
            .mc_rd_count (rdCount),
            .mc_wr_count (wrCount)
`endif
        );

        // Monitor: every mc_done pulse must match the oldest queued expectation
        always @(negedge clock) begin : monitor
            exp_t e;
            if (!reset && done) begin
                if (sbQ.size() == 0) begin
                    failNote($sformatf("L%0d_unexpected_done", g));
                end else begin
                    e = sbQ.pop_front();
                    check($sformatf("L%0d_done_edge", g), 32'(edgeCount), 32'(e.doneEdge));
                    if (e.isRead) check($sformatf("L%0d_read_data", g), mcData, e.data);
                end
            end
        end

        // Stimulus steps just after the falling edge, clear of the monitor
        task automatic tick;
            @(negedge clock);
            #1;
        endtask

        function automatic logic [31:0] refRead(input logic [17:0] a);
            int k = int'(a[16:0]);
            return refMem.exists(k) ? refMem[k] : 32'h0;
        endfunction

        task automatic waitIdle;
            int b = 0;
            tick;
            while (busy && b < 200) begin
                tick;
                b++;
            end
            if (busy) failNote($sformatf("L%0d_idle_timeout", g));
        endtask

        task automatic checkReset(input string tag);
            check($sformatf("L%0d_%s_strobes", g, tag), 32'({ceN, oeN, weN, ubN, lbN}), 32'h1F);
            check($sformatf("L%0d_%s_busy", g, tag), 32'(busy), 32'h0);
            check($sformatf("L%0d_%s_done", g, tag), 32'(done), 32'h0);
            check($sformatf("L%0d_%s_addr", g, tag), 32'(sramAddr), 32'h0);
        endtask

        task automatic checkCounts(input string tag);
`ifdef MC_ACCESS_COUNT_EN
            check($sformatf("L%0d_%s_rd_count", g, tag), 32'(rdCount), 32'(refRd));
            check($sformatf("L%0d_%s_wr_count", g, tag), 32'(wrCount), 32'(refWr));
`else
            if (tag.len() < 0) $display("[TB] %s", tag);
`endif
        endtask

        // One complete access; the expected outcome comes from the word-level model
        task automatic access(input bit isWrite, input logic [17:0] a, input logic [31:0] d);
            exp_t e;
            int   b = 0;
            int   weLo = 0;
            int   weHi = 0;
            waitIdle;
            en = 1'b1;
            rw = isWrite;
            addr = a;
            tbData = d;
            tbDrive = isWrite;
            e.isRead = !isWrite;
            e.data = isWrite ? 32'h0 : refRead(a);
            e.doneEdge = edgeCount + 1 + LAT;
            sbQ.push_back(e);
            if (isWrite) begin
                refMem[int'(a[16:0])] = d;
                refWr++;
            end else begin
                refRd++;
            end
            tick;
            tbDrive = 1'b0;
            while (!done && b < 200) begin
                if (!weN) begin
                    if (sramAddr[0]) weHi++;
                    else weLo++;
                end
                if (isWrite && lastRead != 32'h0) checkDiffer($sformatf("L%0d_wr_bus_free", g), mcData, lastRead);
                tick;
                b++;
            end
            if (!done) failNote($sformatf("L%0d_done_timeout", g));
            en = 1'b0;
            if (isWrite) begin
                check($sformatf("L%0d_we_low_lo", g), 32'(weLo), 32'(WS + 1));
                check($sformatf("L%0d_we_low_hi", g), 32'(weHi), 32'(WS + 1));
            end else begin
                lastRead = e.data;
            end
        endtask

        // Read with enable held through DONE: the controller repeats it
        task automatic heldRead(input logic [17:0] a);
            exp_t e;
            int   b = 0;
            int   dones = 0;
            waitIdle;
            en = 1'b1;
            rw = 1'b0;
            addr = a;
            e.isRead = 1'b1;
            e.data = refRead(a);
            e.doneEdge = edgeCount + 1 + LAT;
            sbQ.push_back(e);
            e.doneEdge = e.doneEdge + 2 + LAT;
            sbQ.push_back(e);
            refRd += 2;
            while (dones < 2 && b < 400) begin
                tick;
                b++;
                if (done) dones++;
            end
            if (dones < 2) failNote($sformatf("L%0d_held_timeout", g));
            en = 1'b0;
            lastRead = e.data;
        endtask

        // Write interrupted by reset while the high half is being driven
        task automatic abortWrite(input logic [17:0] a, input logic [31:0] d);
            int          b = 0;
            int          accept;
            logic [31:0] old = refRead(a);
            waitIdle;
            en = 1'b1;
            rw = 1'b1;
            addr = a;
            tbData = d;
            tbDrive = 1'b1;
            accept = edgeCount + 1;
            tick;
            tbDrive = 1'b0;
            while (edgeCount != accept + WS + 1 && b < 200) begin
                @(posedge clock);
                #1;
                b++;
            end
            reset = 1'b1;
            en = 1'b0;
            #1;
            checkReset("abort");
            checkDiffer($sformatf("L%0d_abort_dq", g), 32'(sramDq), 32'(d[31:16]));
            refMem[int'(a[16:0])] = {old[31:16], d[15:0]};
            lastRead = 32'h0;
            refRd = 0;
            refWr = 0;
            repeat (2) tick;
            reset = 1'b0;
            tick;
        endtask

        // Directed cases first, then a randomized mix, then the reset abort
        initial begin
            logic [17:0] a;
            reset = 1'b1;
            en = 1'b0;
            rw = 1'b0;
            addr = '0;
            tbData = '0;
            tbDrive = 1'b0;
            lastRead = 32'h0;
            refRd = 0;
            refWr = 0;
            repeat (3) tick;
            checkReset("reset");
            checkCounts("reset");
            reset = 1'b0;
            tick;

            access(1'b1, 18'h00010, 32'hDEADBEEF);
            tick;
            check($sformatf("L%0d_sram_lo_half", g), 32'(sramMem[18'h00020]), 32'h0000BEEF);
            check($sformatf("L%0d_sram_hi_half", g), 32'(sramMem[18'h00021]), 32'h0000DEAD);
            access(1'b0, 18'h00010, 32'h0);
            tick;
            checkDiffer($sformatf("L%0d_rd_bus_release", g), mcData, lastRead);

            access(1'b1, 18'h00005, $urandom | 32'h1);
            heldRead(18'h00005);

            for (int i = 0; i < 24; i++) begin
                a = {1'($urandom), 13'h0, 4'($urandom_range(0, 15))};
                access(1'($urandom), a, $urandom);
            end
            checkCounts("mix");

            access(1'b1, 18'h00007, 32'h1234_5678);
            abortWrite(18'h00007, 32'hA5A5_C3C3);
            access(1'b0, 18'h00007, 32'h0);
            check($sformatf("L%0d_abort_word", g), lastRead, 32'h1234_C3C3);
            checkCounts("after_abort");
            tick;
            check($sformatf("L%0d_sb_empty", g), 32'(sbQ.size()), 32'h0);
            laneDone[g] = 1'b1;
        end
    end

    // Wait for both lanes, bounded, then report
    initial begin
        int b = 0;
        while (!(laneDone[0] && laneDone[1]) && b < 20000) begin
            @(negedge clock);
            b++;
        end
        if (!(laneDone[0] && laneDone[1])) failNote("lane_timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sram_memory_controller.md
Name: sram_memory_controller

Overview:
- Sits directly downstream of the pipeline Memory stage. Consumes its mem_mc_rw / mem_mc_en / mem_mc_addr / mem_mc_data request.
- Performs each 32-bit word access as two 16-bit accesses on the board's external asynchronous SRAM (256K x 16, 18-bit address).
- On reads, returns the assembled 32-bit word onto the shared mem_mc_data bus.
- Raises mc_done for one cycle when an access completes, so the pipeline can advance.

Parameters:
- WAIT_STATES, 0: extra clock cycles held per half-word access, to stretch SRAM timing. Legal range 0..7.
- ADDR_W, 18: SRAM address width.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_mc_en  in  1  access request from the Memory stage.
- mem_mc_rw  in  1  1 = write, 0 = read.
- mem_mc_addr  in  18  word address.
- mem_mc_data  inout  32  write data in; read data out.
- mc_busy  out  1  access in progress (state != IDLE).
- mc_done  out  1  one-cycle pulse when an access completes.
- sram_addr  out  18  SRAM address.
- sram_dq  inout  16  SRAM data.
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, all active-low.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE.
  - sram_ce_n, sram_oe_n, sram_we_n = 1; sram_ub_n, sram_lb_n = 1.
  - sram_addr = 0; sram_dq and mem_mc_data tri-stated.
  - Internal read-data register = 0; mc_busy = 0; mc_done = 0.
- FSM states: IDLE -> LO -> HI -> DONE -> IDLE.
- IDLE:
  - If mem_mc_en = 1 at the clock edge, latch addr, rw and (if rw = 1) mem_mc_data[31:0]; go to LO.
  - Otherwise stay in IDLE with all strobes high.
- LO:
  - sram_addr = {addr[16:0], 1'b0}; ce_n = 0, ub_n = 0, lb_n = 0.
  - Write: we_n = 0, oe_n = 1, sram_dq = wdata[15:0].
  - Read: oe_n = 0, we_n = 1, sram_dq tri-stated; sram_dq is sampled into rdata[15:0] on the last cycle of the state.
  - Stays WAIT_STATES+1 cycles, counted by a wait counter that resets on each state entry; then goes to HI.
- HI: same as LO with sram_addr = {addr[16:0], 1'b1}, wdata[31:16] and rdata[31:16]; then goes to DONE.
- DONE:
  - mc_done = 1 for exactly one cycle; all strobes high; then goes to IDLE.
- Latency: request accepted at edge N; mc_done is high during cycle N + 2*(WAIT_STATES+1) + 1. With WAIT_STATES = 0, mc_done is high in the 3rd cycle after acceptance.
- Address: mem_mc_addr[17] is ignored. The usable space is 128K words; the low half is at the even SRAM address.
- Bus ownership on mem_mc_data:
  - The controller drives the rdata register onto mem_mc_data only while mem_mc_en = 1 and mem_mc_rw = 0.
  - It tri-states the bus otherwise, so it never contends with a Memory-stage write.
  - rdata holds its value until the next read updates it.
- Request changes:
  - Changes on mem_mc_en, mem_mc_rw or mem_mc_addr during LO/HI/DONE are ignored; values are latched only in IDLE.
  - If mem_mc_en is still 1 in the IDLE cycle after DONE, a new access starts. The requester must drop mem_mc_en on seeing mc_done if it does not want a repeat.
- Both strobe halves are always enabled; no byte writes.
- sram_dq is driven only in write LO/HI states. we_n and dq change together with state. Address stability across the write is guaranteed by one-state granularity (WAIT_STATES ≥ 1 recommended on hardware).
- Reset asserted mid-access aborts the access. A write may leave only the low half written; this is acceptable.

Optional Feature:
- Macro: MC_ACCESS_COUNT_EN.
- Defined:
  - Adds output ports mc_rd_count[15:0] and mc_wr_count[15:0].
  - Each counter increments on entry to DONE for its access type, saturates at 16'hFFFF, and is cleared by reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package mc_pkg holds:
  - FSM state encoding: IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3.
  - SRAM_DATA_W = 16 and WORD_W = 32.
  - Strobe-inactive constant.
- One natural sub-module: mc_wait_counter. It is a loadable down-counter with a zero flag and sequences the WAIT_STATES stretch; it is instantiated once.

Test Plan:
- Write then read, WAIT_STATES = 0:
  - Write addr 0x00010 data 0xDEADBEEF. SRAM model must hold 0xBEEF at 0x00020 and 0xDEAD at 0x00021.
  - Read addr 0x00010. mem_mc_data = 0xDEADBEEF; mc_done is high exactly 3 cycles after acceptance.
- WAIT_STATES = 3: read returns correct data; mc_done arrives 9 cycles after acceptance; we_n stays low 4 cycles per half during writes.
- Held enable: keep mem_mc_en = 1 with a read of addr 0x00005 through DONE. A second access starts in the following IDLE; mc_done pulses twice, 4 cycles apart.
- Reset mid-write: assert reset during HI. All strobes go high immediately, sram_dq goes to Z, and the FSM is in IDLE. The next read of the same address returns the new low half with the old high half.
- Bus contention: during a write request, the controller never drives mem_mc_data (checked every cycle). After a read with mem_mc_en = 0, mem_mc_data is Z.
- With MC_ACCESS_COUNT_EN defined: after 2 writes and 3 reads, mc_wr_count = 2 and mc_rd_count = 3; both are 0 after reset.
